// File: rtl/rf_writeback.sv
// rf_writeback -- write-side controller for the 32x32 register file.
//
// Merges single-cycle ALU results and buffered long-latency results (loads,
// multi-cycle multiply) onto the file's one write port. Long-latency results
// queue in a DEPTH-entry circular FIFO. A 32-bit scoreboard tracks the
// destinations of in-flight long-latency ops and raises a RAW hazard to decode.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   alu_valid/alu_rd/alu_wd    ALU result (no backpressure, owns the port)
//   mem_valid/mem_ready        long-latency result handshake
//   mem_rd/mem_wd              long-latency destination and data
//   issue_valid/issue_rd       long-latency op dispatched by decode
//   rs1, rs2 / hazard          decode sources and their pending status
//   we3/a3/wd3                 register file write port
//   busy_mask                  scoreboard of pending long-latency writes
//   fifo_count                 current FIFO occupancy
module rf_writeback #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_rd,
  input  logic [XLEN-1:0]          alu_wd,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [4:0]               mem_rd,
  input  logic [XLEN-1:0]          mem_wd,
  input  logic                     issue_valid,
  input  logic [4:0]               issue_rd,
  input  logic [4:0]               rs1,
  input  logic [4:0]               rs2,
  output logic                     hazard,
  output logic                     we3,
  output logic [4:0]               a3,
  output logic [XLEN-1:0]          wd3,
  output logic [31:0]              busy_mask,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // FIFO storage carries data only, so it is left unreset.
  logic [4:0]      fifo_rd_q [DEPTH];
  logic [XLEN-1:0] fifo_wd_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic [31:0]   busy_q,   busy_d;

  logic            push;
  logic            pop;
  logic            fifo_empty;
  logic [4:0]      head_rd;
  logic [XLEN-1:0] head_wd;

  assign fifo_empty = (count_q == '0);
  assign mem_ready  = (count_q < CW'(DEPTH));
  assign push       = mem_valid && mem_ready;
  // ALU has absolute priority; the FIFO only drains in ALU-idle cycles.
  assign pop        = !alu_valid && !fifo_empty;
  assign head_rd    = fifo_rd_q[rd_ptr_q];
  assign head_wd    = fifo_wd_q[rd_ptr_q];

  // Write-port mux. Gated by rst_n so the port stays quiet during reset even
  // if the ALU keeps presenting results.
  always_comb begin
    we3 = 1'b0;
    a3  = '0;
    wd3 = '0;
    if (rst_n) begin
      if (alu_valid) begin
        we3 = (alu_rd != 5'd0);
        a3  = alu_rd;
        wd3 = alu_wd;
      end else if (!fifo_empty) begin
        we3 = (head_rd != 5'd0);
        a3  = head_rd;
        wd3 = head_wd;
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // Clear before set so a same-cycle issue to the popping register wins.
  always_comb begin
    busy_d = busy_q;
    if (pop && head_rd != 5'd0)
      busy_d[head_rd] = 1'b0;
    if (issue_valid && issue_rd != 5'd0)
      busy_d[issue_rd] = 1'b1;
  end

  assign hazard = ((rs1 != 5'd0) && busy_q[rs1]) ||
                  ((rs2 != 5'd0) && busy_q[rs2]);

  assign busy_mask  = busy_q;
  assign fifo_count = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      busy_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q] <= mem_rd;
      fifo_wd_q[wr_ptr_q] <= mem_wd;
    end
  end

endmodule

// File: tb/tb_rf_writeback.sv
module tb_rf_writeback;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_wd;
  logic            mem_valid;
  logic            mem_ready;
  logic [4:0]      mem_rd;
  logic [XLEN-1:0] mem_wd;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic [4:0]      rs1, rs2;
  logic            hazard;
  logic            we3;
  logic [4:0]      a3;
  logic [XLEN-1:0] wd3;
  logic [31:0]     busy_mask;
  logic [$clog2(DEPTH):0] fifo_count;

  rf_writeback #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_wd(alu_wd),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_wd(mem_wd),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1(rs1), .rs2(rs2), .hazard(hazard),
    .we3(we3), .a3(a3), .wd3(wd3),
    .busy_mask(busy_mask), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = 0; alu_wd = 0;
    mem_valid = 0; mem_rd = 0; mem_wd = 0;
    issue_valid = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
  endtask

  // Leaves the bench at posedge+1 with reset released.
  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  typedef struct {
    logic        av; logic [4:0] ard; logic [31:0] awd;
    logic        mv; logic [4:0] mrd; logic [31:0] mwd;
    logic        iv; logic [4:0] ird;
    logic [4:0]  r1; logic [4:0] r2;
    logic        e_we; logic [4:0] e_a3; logic [31:0] e_wd;
    logic        e_haz; logic e_rdy; logic [2:0] e_cnt; logic [31:0] e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic av, logic [4:0] ard, logic [31:0] awd,
                              logic mv, logic [4:0] mrd, logic [31:0] mwd,
                              logic iv, logic [4:0] ird, logic [4:0] r1, logic [4:0] r2,
                              logic e_we, logic [4:0] e_a3, logic [31:0] e_wd,
                              logic e_haz, logic e_rdy, logic [2:0] e_cnt, logic [31:0] e_busy);
    vec_t v;
    v.av = av; v.ard = ard; v.awd = awd; v.mv = mv; v.mrd = mrd; v.mwd = mwd;
    v.iv = iv; v.ird = ird; v.r1 = r1; v.r2 = r2;
    v.e_we = e_we; v.e_a3 = e_a3; v.e_wd = e_wd; v.e_haz = e_haz;
    v.e_rdy = e_rdy; v.e_cnt = e_cnt; v.e_busy = e_busy;
    return v;
  endfunction

  // Reference model state: queue of pending long-latency results + busy bits.
  typedef struct { logic [4:0] rd; logic [31:0] wd; } ent_t;
  ent_t        mq[$];
  logic [31:0] mbusy;

  initial begin
    logic        m_we;
    logic [4:0]  m_a3;
    logic [31:0] m_wd;
    logic        m_rdy;
    logic        m_haz;
    ent_t        e;

    // One row per cycle, starting right after reset. Expected values are the
    // outputs observed during that cycle, before its closing edge.
    //          av ard awd          mv mrd mwd       iv ird r1 r2  we a3 wd           hz rdy cnt busy
    vecs.push_back(mk(0, 0, 0,           0, 0, 0,       0, 0, 0, 0,  0, 0, 0,           0, 1, 0, 32'h0));   // idle
    vecs.push_back(mk(1, 5, 32'hDEADBEEF,0, 0, 0,       0, 0, 0, 0,  1, 5, 32'hDEADBEEF,0, 1, 0, 32'h0));   // alu write
    vecs.push_back(mk(1, 0, 32'h55,      0, 0, 0,       0, 0, 0, 0,  0, 0, 32'h55,      0, 1, 0, 32'h0));   // alu x0
    vecs.push_back(mk(0, 0, 0,           0, 0, 0,       1, 7, 0, 0,  0, 0, 0,           0, 1, 0, 32'h0));   // issue x7
    vecs.push_back(mk(0, 0, 0,           0, 0, 0,       0, 0, 7, 0,  0, 0, 0,           1, 1, 0, 32'h80));  // hazard
    vecs.push_back(mk(0, 0, 0,           1, 7, 32'h1234,0, 0, 7, 0,  0, 0, 0,           1, 1, 0, 32'h80));  // push x7
    vecs.push_back(mk(0, 0, 0,           0, 0, 0,       0, 0, 7, 0,  1, 7, 32'h1234,    1, 1, 1, 32'h80));  // pop x7
    vecs.push_back(mk(0, 0, 0,           0, 0, 0,       0, 0, 7, 0,  0, 0, 0,           0, 1, 0, 32'h0));   // cleared
    vecs.push_back(mk(1, 3, 32'hAAAA,    1, 10, 32'h100,0, 0, 0, 0,  1, 3, 32'hAAAA,    0, 1, 0, 32'h0));
    vecs.push_back(mk(1, 3, 32'hAAAA,    1, 11, 32'h101,0, 0, 0, 0,  1, 3, 32'hAAAA,    0, 1, 1, 32'h0));
    vecs.push_back(mk(1, 3, 32'hAAAA,    1, 12, 32'h102,0, 0, 0, 0,  1, 3, 32'hAAAA,    0, 1, 2, 32'h0));
    vecs.push_back(mk(1, 3, 32'hAAAA,    1, 13, 32'h103,0, 0, 0, 0,  1, 3, 32'hAAAA,    0, 1, 3, 32'h0));
    vecs.push_back(mk(1, 3, 32'hAAAA,    1, 14, 32'h104,0, 0, 0, 0,  1, 3, 32'hAAAA,    0, 0, 4, 32'h0));   // full
    vecs.push_back(mk(0, 0, 0,           1, 14, 32'h104,0, 0, 0, 0,  1, 10, 32'h100,    0, 0, 4, 32'h0));   // pop, no push
    vecs.push_back(mk(0, 0, 0,           0, 0, 0,       0, 0, 0, 0,  1, 11, 32'h101,    0, 1, 3, 32'h0));
    vecs.push_back(mk(0, 0, 0,           1, 15, 32'h200,0, 0, 0, 0,  1, 12, 32'h102,    0, 1, 2, 32'h0));   // push+pop at 2
    vecs.push_back(mk(0, 0, 0,           0, 0, 0,       0, 0, 0, 0,  1, 13, 32'h103,    0, 1, 2, 32'h0));
    vecs.push_back(mk(0, 0, 0,           0, 0, 0,       0, 0, 0, 0,  1, 15, 32'h200,    0, 1, 1, 32'h0));
    vecs.push_back(mk(0, 0, 0,           0, 0, 0,       1, 9, 0, 0,  0, 0, 0,           0, 1, 0, 32'h0));   // issue x9
    vecs.push_back(mk(0, 0, 0,           1, 9, 32'h999, 0, 0, 0, 9,  0, 0, 0,           1, 1, 0, 32'h200));
    vecs.push_back(mk(0, 0, 0,           0, 0, 0,       1, 9, 0, 9,  1, 9, 32'h999,     1, 1, 1, 32'h200)); // set wins
    vecs.push_back(mk(0, 0, 0,           1, 0, 32'h77,  0, 0, 0, 9,  0, 0, 0,           1, 1, 0, 32'h200));
    vecs.push_back(mk(0, 0, 0,           0, 0, 0,       0, 0, 9, 0,  0, 0, 32'h77,      1, 1, 1, 32'h200)); // x0 pop
    vecs.push_back(mk(0, 0, 0,           0, 0, 0,       0, 0, 9, 0,  0, 0, 0,           1, 1, 0, 32'h200));

    do_reset();
    foreach (vecs[i]) begin
      alu_valid = vecs[i].av; alu_rd = vecs[i].ard; alu_wd = vecs[i].awd;
      mem_valid = vecs[i].mv; mem_rd = vecs[i].mrd; mem_wd = vecs[i].mwd;
      issue_valid = vecs[i].iv; issue_rd = vecs[i].ird;
      rs1 = vecs[i].r1; rs2 = vecs[i].r2;
      @(negedge clk);
      check($sformatf("vec%0d.we3", i),        we3,        vecs[i].e_we);
      check($sformatf("vec%0d.a3", i),         a3,         vecs[i].e_a3);
      check($sformatf("vec%0d.wd3", i),        wd3,        vecs[i].e_wd);
      check($sformatf("vec%0d.hazard", i),     hazard,     vecs[i].e_haz);
      check($sformatf("vec%0d.mem_ready", i),  mem_ready,  vecs[i].e_rdy);
      check($sformatf("vec%0d.fifo_count", i), fifo_count, vecs[i].e_cnt);
      check($sformatf("vec%0d.busy_mask", i),  busy_mask,  vecs[i].e_busy);
      @(posedge clk); #1;
    end

    // Asynchronous reset mid-operation: 3 queued results, x1..x3 pending.
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      alu_valid = 1; alu_rd = 5'd20; alu_wd = 32'hA1;
      mem_valid = 1; mem_rd = 5'(k); mem_wd = 32'(k);
      issue_valid = 1; issue_rd = 5'(k);
      @(posedge clk); #1;
    end
    mem_valid = 0; issue_valid = 0;
    @(negedge clk);
    check("pre_rst.fifo_count", fifo_count, 3);
    check("pre_rst.busy_mask",  busy_mask,  32'h0E);
    #1 rst_n = 0;
    #1;
    check("async_rst.fifo_count", fifo_count, 0);
    check("async_rst.busy_mask",  busy_mask,  0);
    check("async_rst.we3",        we3,        0);
    check("async_rst.mem_ready",  mem_ready,  1);
    @(posedge clk); #1;
    rst_n = 1; idle_inputs();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("post_rst%0d.we3", k),        we3,        0);
      check($sformatf("post_rst%0d.fifo_count", k), fifo_count, 0);
      check($sformatf("post_rst%0d.hazard", k),     hazard,     0);
      @(posedge clk); #1;
    end

    // Randomized run against the queue-based model.
    do_reset();
    mq.delete();
    mbusy = '0;
    for (int c = 0; c < 3000; c++) begin
      alu_valid   = ($urandom_range(0, 9) < 3);
      alu_rd      = 5'($urandom_range(0, 7));
      alu_wd      = $urandom;
      mem_valid   = ($urandom_range(0, 9) < 6);
      mem_rd      = 5'($urandom_range(0, 7));
      mem_wd      = $urandom;
      issue_valid = ($urandom_range(0, 9) < 3);
      issue_rd    = 5'($urandom_range(0, 7));
      rs1         = 5'($urandom_range(0, 7));
      rs2         = 5'($urandom_range(0, 7));

      m_rdy = (mq.size() < DEPTH);
      m_haz = (rs1 != 0 && mbusy[rs1]) || (rs2 != 0 && mbusy[rs2]);
      if (alu_valid) begin
        m_we = (alu_rd != 0); m_a3 = alu_rd; m_wd = alu_wd;
      end else if (mq.size() > 0) begin
        m_we = (mq[0].rd != 0); m_a3 = mq[0].rd; m_wd = mq[0].wd;
      end else begin
        m_we = 0; m_a3 = 0; m_wd = 0;
      end

      @(negedge clk);
      check("rnd.we3",        we3,        m_we);
      if (m_we) begin
        check("rnd.a3",       a3,         m_a3);
        check("rnd.wd3",      wd3,        m_wd);
      end
      check("rnd.hazard",     hazard,     m_haz);
      check("rnd.mem_ready",  mem_ready,  m_rdy);
      check("rnd.fifo_count", fifo_count, mq.size());
      check("rnd.busy_mask",  busy_mask,  mbusy);

      // Advance the model across the coming edge.
      if (!alu_valid && mq.size() > 0) begin
        e = mq.pop_front();
        if (e.rd != 0) mbusy[e.rd] = 1'b0;
      end
      if (issue_valid && issue_rd != 0) mbusy[issue_rd] = 1'b1;
      if (mem_valid && m_rdy) begin
        e.rd = mem_rd; e.wd = mem_wd;
        mq.push_back(e);
      end
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_writeback.md
# rf_writeback

Write-side controller for the 32×32 register file. Merges results from the single-cycle ALU path and from a long-latency path (loads, multi-cycle multiply) onto the file's single write port (we3/a3/wd3). Long-latency results are buffered in a small FIFO. A 32-bit scoreboard of pending long-latency destinations drives a read-after-write hazard signal back to decode.

## Interface
- DEPTH, 4: long-latency result FIFO entries; power of two, ≥2
- XLEN, 32: data width
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- alu_valid  in  1  ALU result present this cycle; no backpressure
- alu_rd  in  5  ALU destination register
- alu_wd  in  XLEN  ALU result
- mem_valid  in  1  long-latency result offered
- mem_ready  out  1  FIFO can accept; transfer when mem_valid && mem_ready
- mem_rd  in  5  long-latency destination register
- mem_wd  in  XLEN  long-latency result
- issue_valid  in  1  decode dispatches a long-latency op this cycle
- issue_rd  in  5  its destination register
- rs1, rs2  in  5  source registers of the instruction in decode
- hazard  out  1  rs1 or rs2 is pending in the scoreboard
- we3  out  1  register file write enable
- a3  out  5  register file write address
- wd3  out  XLEN  register file write data
- busy_mask  out  32  scoreboard; bit r set = long-latency write to xr pending
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- Write-port arbitration, evaluated combinationally each cycle:
  - alu_valid=1: ALU owns the port. we3=(alu_rd!=0), a3=alu_rd, wd3=alu_wd. FIFO does not pop.
  - else FIFO non-empty: pop head. we3=(head_rd!=0), a3=head_rd, wd3=head_wd.
  - else we3=0, a3=0, wd3=0.
- Destination x0 is never written (we3=0). The request is still consumed: an ALU x0 result is dropped, and a FIFO x0 entry still pops.
- FIFO:
  - Circular buffer with read/write pointers and a count.
  - Push on mem_valid && mem_ready.
  - mem_ready = (fifo_count < DEPTH). It depends on registered count only, so there is no same-cycle pass-through when full.
  - No fall-through: an entry pushed at the edge ending cycle N can pop no earlier than cycle N+1.
  - Pointers wrap modulo DEPTH.
- Scoreboard:
  - Set: issue_valid && issue_rd!=0 sets busy_mask[issue_rd] at the next edge.
  - Clear: a FIFO pop with head_rd!=0 clears busy_mask[head_rd] at the same edge as the register file write.
  - Same bit set and cleared in one cycle: set wins.
  - ALU writes never touch busy_mask.
- hazard = (rs1!=0 && busy_mask[rs1]) || (rs2!=0 && busy_mask[rs2]); combinational.
- Decode guarantees it does not send an ALU write to a busy register. Behaviour in that case is unspecified: no assertion, no check.

## Timing
- Reset (rst_n low, asynchronous): FIFO empty, pointers 0, fifo_count=0, busy_mask=0. While rst_n is low, we3=0 and a3, wd3 are forced 0.
- After reset, mem_ready=1 and hazard=0.
- Reset mid-operation discards all buffered results and pending bits; no write issues for them.
- ALU result: written at the rising edge ending the cycle in which alu_valid is high (0 added cycles).
- Long-latency result: accepted at edge E, written at the earliest edge E+1, later if the ALU is using the port.
- Push and pop in the same cycle: count unchanged.
  - If count=DEPTH, mem_ready=0 that cycle, so no push occurs even though a pop frees a slot.
- Sustained alu_valid stalls the FIFO indefinitely. Starvation avoidance is decode's responsibility, which uses hazard.
- busy_mask, fifo_count and mem_ready update only on clock edges (or asynchronous reset).

## Test plan
- Reset then idle: we3=0, mem_ready=1, busy_mask=0, fifo_count=0, hazard=0.
- ALU path: alu_valid=1, alu_rd=5, alu_wd=0xDEADBEEF → same cycle we3=1, a3=5, wd3=0xDEADBEEF. alu_rd=0 → we3=0.
- Scoreboard and hazard:
  - issue x7 → next cycle busy_mask=0x80; rs1=7 gives hazard=1.
  - Push mem_rd=7, wd=0x1234 with alu_valid=0 → written next cycle (a3=7, wd3=0x1234); busy_mask=0 after that edge; hazard=0.
- Priority and backpressure, DEPTH=4:
  - Hold alu_valid=1 and push 4 mem results → fifo_count=4, mem_ready=0, no FIFO writes.
  - Drop alu_valid → entries written in push order on 4 consecutive cycles; mem_ready=1 once count=3.
- Simultaneous events:
  - Push and pop in one cycle at count=2 → count stays 2.
  - issue x9 in the same cycle a FIFO x9 entry pops → busy_mask[9] remains 1.
- Asynchronous reset with 3 entries queued and busy_mask=0x0E → immediately fifo_count=0, busy_mask=0, we3=0. No writes occur after release.
